// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// iteration-counter sizing.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter has to hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle of seq_divider: valid/ready on the operand side and
// the result side, plus the busy status.
interface seq_divider_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             out_div_zero;
    logic             busy;

    modport master (
        output in_valid, in_dividend, in_divisor, in_signed, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_div_zero, busy
    );

    modport slave (
        input  in_valid, in_dividend, in_divisor, in_signed, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_div_zero, busy
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, trial-subtract
// the divisor and keep the difference only when it does not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           borrow;
    logic           unused_msb;

    assign shifted = {rem, quo[WIDTH-1]};
    assign {borrow, trial} = {1'b0, shifted} - {2'b00, divisor};

    // rem < divisor is invariant, so the kept value always fits in WIDTH bits.
    assign rem_next   = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next   = {quo[WIDTH-2:0], ~borrow};
    assign unused_msb = trial[WIDTH] ^ shifted[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to honour in_signed; otherwise every operation is unsigned.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          resetn,
    seq_divider_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic [WIDTH-1:0] q_res, r_res;
    logic [CW-1:0]    count;
    logic             dz, q_neg, r_neg;

    logic             op_signed, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_abs, b_abs;

`ifdef DIV_SIGNED_EN
    assign op_signed = bus.in_signed;
`else
    logic unused_signed;
    assign op_signed     = 1'b0;
    assign unused_signed = bus.in_signed;
`endif

    assign a_neg  = op_signed & bus.in_dividend[WIDTH-1];
    assign b_neg  = op_signed & bus.in_divisor[WIDTH-1];
    assign b_zero = (bus.in_divisor == '0);
    assign a_abs  = a_neg ? -bus.in_dividend : bus.in_dividend;
    assign b_abs  = b_neg ? -bus.in_divisor  : bus.in_divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid)      state_nxt = CALC;
            CALC: if (count == CW'(1))   state_nxt = FIX;
            FIX:                         state_nxt = DONE;
            DONE: if (bus.out_ready)     state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            q_res <= '0;
            r_res <= '0;
            count <= '0;
            dz    <= 1'b0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (bus.in_valid) begin
                    quo   <= a_abs;
                    dvs   <= b_abs;
                    rem   <= '0;
                    count <= CW'(WIDTH);
                    dz    <= b_zero;
                    // Keep q = all ones on divide-by-zero; remainder still
                    // regains the dividend sign so it equals the dividend.
                    q_neg <= (a_neg ^ b_neg) & ~b_zero;
                    r_neg <= a_neg;
                end
                CALC: begin
                    rem   <= rem_step;
                    quo   <= quo_step;
                    count <= count - 1'b1;
                end
                FIX: begin
                    q_res <= q_neg ? -quo : quo;
                    r_res <= r_neg ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready      = (state == IDLE);
    assign bus.busy          = (state != IDLE);
    assign bus.out_valid     = (state == DONE);
    assign bus.out_quotient  = q_res;
    assign bus.out_remainder = r_res;
    assign bus.out_div_zero  = dz;

endmodule
